// File: rtl/shift_out_pkg.sv
// Shared definitions for the shift_out_gen serialiser.
package shift_out_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_out_gen_if.sv
// Parallel-in / serial-out bus bundle for shift_out_gen.
interface shift_out_gen_if #(
  parameter int unsigned WIDTH = 24
);
  logic [WIDTH-1:0] z_parallel;
  logic             sz;
  logic             z_out;
  logic             fz;
  logic             ready;
  logic             done;

  modport master (
    output z_parallel, sz,
    input  z_out, fz, ready, done
  );

  modport slave (
    input  z_parallel, sz,
    output z_out, fz, ready, done
  );
endinterface

// File: rtl/rise_detect.sv
// Registered rising-edge detector; the history flop resets high so a level already
// high at reset release is not seen as an edge.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic in_q,
  output logic rise
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_q <= 1'b1;
    end else begin
      in_q <= in;
    end
  end

  assign rise = in & ~in_q;

endmodule

// File: rtl/shift_out_gen.sv
// Serialises a WIDTH-bit word on a start edge; every output is driven straight from a flop.
module shift_out_gen
  import shift_out_pkg::*;
#(
  parameter int unsigned WIDTH     = 24,
  parameter bit          MSB_FIRST = 1'b0
) (
  input logic            clk,
  input logic            reset,
  shift_out_gen_if.slave bus
);

  localparam int unsigned     CntW     = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast  = CntW'(WIDTH - 1);
  localparam int unsigned     FirstIdx = MSB_FIRST ? WIDTH - 1 : 0;
  localparam int unsigned     NextIdx  = MSB_FIRST ? WIDTH - 2 : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             z_out_q, z_out_d;
  logic             fz_q, fz_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             start;
  logic             unused_sz_q;

  rise_detect u_rise_detect (
    .clk   (clk),
    .reset (reset),
    .in    (bus.sz),
    .in_q  (unused_sz_q),
    .rise  (start)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StShift;
      StShift: if (cnt_q == CntLast) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Next values of the output flops; z_out_d always looks one bit ahead of z_out_q.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    z_out_d = 1'b0;
    fz_d    = 1'b0;
    ready_d = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          shreg_d = bus.z_parallel;
          cnt_d   = '0;
          z_out_d = bus.z_parallel[FirstIdx];
          fz_d    = 1'b1;
        end else begin
          ready_d = 1'b1;
        end
      end
      StShift: begin
        if (cnt_q == CntLast) begin
          done_d = 1'b1;
        end else begin
          shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
          cnt_d   = cnt_q + 1'b1;
          z_out_d = shreg_q[NextIdx];
          fz_d    = 1'b1;
        end
      end
      StDone:  ready_d = 1'b1;
      default: ready_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      z_out_q <= 1'b0;
      fz_q    <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      z_out_q <= z_out_d;
      fz_q    <= fz_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign bus.z_out = z_out_q;
  assign bus.fz    = fz_q;
  assign bus.ready = ready_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_shift_out_gen.sv
// Directed bench for shift_out_gen: LSB-first and MSB-first 24-bit instances plus a 2-bit one.
module tb_shift_out_gen;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  shift_out_gen_if #(.WIDTH(24)) bus_l ();
  shift_out_gen_if #(.WIDTH(24)) bus_m ();
  shift_out_gen_if #(.WIDTH(2))  bus_2 ();

  shift_out_gen #(.WIDTH(24), .MSB_FIRST(1'b0)) u_dut_l (.clk(clk), .reset(reset), .bus(bus_l));
  shift_out_gen #(.WIDTH(24), .MSB_FIRST(1'b1)) u_dut_m (.clk(clk), .reset(reset), .bus(bus_m));
  shift_out_gen #(.WIDTH(2),  .MSB_FIRST(1'b0)) u_dut_2 (.clk(clk), .reset(reset), .bus(bus_2));

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Frame monitors: bit i of seq_* is the i-th bit seen while fz was high.
  int nb_l = 0, fr_l = 0, dn_l = 0, len_l = 0, inv_l = 0;
  int nb_m = 0, fr_m = 0, dn_m = 0, len_m = 0, inv_m = 0;
  int inv_2 = 0;
  logic [63:0] cur_l = '0, seq_l = '0, cur_m = '0, seq_m = '0;

  always @(negedge clk) begin
    if (bus_l.fz) begin
      if (nb_l < 64) cur_l[nb_l[5:0]] <= bus_l.z_out;
      nb_l <= nb_l + 1;
    end else if (nb_l != 0) begin
      seq_l <= cur_l; len_l <= nb_l; fr_l <= fr_l + 1; nb_l <= 0; cur_l <= '0;
    end
    if (bus_l.done) dn_l <= dn_l + 1;
    if ((bus_l.ready !== !(bus_l.fz || bus_l.done)) || (!bus_l.fz && bus_l.z_out)) inv_l <= inv_l + 1;
  end

  always @(negedge clk) begin
    if (bus_m.fz) begin
      if (nb_m < 64) cur_m[nb_m[5:0]] <= bus_m.z_out;
      nb_m <= nb_m + 1;
    end else if (nb_m != 0) begin
      seq_m <= cur_m; len_m <= nb_m; fr_m <= fr_m + 1; nb_m <= 0; cur_m <= '0;
    end
    if (bus_m.done) dn_m <= dn_m + 1;
    if ((bus_m.ready !== !(bus_m.fz || bus_m.done)) || (!bus_m.fz && bus_m.z_out)) inv_m <= inv_m + 1;
  end

  always @(negedge clk) begin
    if ((bus_2.ready !== !(bus_2.fz || bus_2.done)) || (!bus_2.fz && bus_2.z_out)) inv_2 <= inv_2 + 1;
  end

  typedef struct {
    logic [23:0] word;
    logic [23:0] exp_lsb;  // bit i = i-th serial bit, LSB-first instance
    logic [23:0] exp_msb;  // bit i = i-th serial bit, MSB-first instance
  } vec_t;

  vec_t vecs[5];
  bit   seq030[24] = '{1,0,0,0,1,1,1,1,1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1};

  initial begin
    logic [23:0] got_l, got_m, exp_l, exp_m;
    int fl0, dl0, fz_miss;

    vecs[0] = '{24'hA5C3F1, 24'hA5C3F1, 24'h8FC3A5};
    vecs[1] = '{24'h000001, 24'h000001, 24'h800000};
    vecs[2] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF};
    vecs[3] = '{24'h123456, 24'h123456, 24'h6A2C48};
    vecs[4] = '{24'h800000, 24'h800000, 24'h000001};

    bus_l.z_parallel = '0; bus_m.z_parallel = '0; bus_2.z_parallel = '0;
    bus_l.sz = 1'b1; bus_m.sz = 1'b1; bus_2.sz = 1'b1;

    // Reset with sz already high
    #1 reset = 1'b0;
    #2;
    check("rst_z_out", bus_l.z_out, 0);
    check("rst_fz", bus_l.fz, 0);
    check("rst_done", bus_l.done, 0);
    check("rst_ready_l", bus_l.ready, 1);
    check("rst_ready_m", bus_m.ready, 1);
    check("rst_ready_2", bus_2.ready, 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("rel_high_no_frame_l", bus_l.fz, 0);
    check("rel_high_no_frame_2", bus_2.fz, 0);
    check("rel_high_ready", bus_l.ready, 1);
    bus_l.sz = 1'b0; bus_m.sz = 1'b0; bus_2.sz = 1'b0;

    // WIDTH=2, word 2'b10
    @(negedge clk); bus_2.z_parallel = 2'b10; bus_2.sz = 1'b1;
    @(negedge clk); bus_2.sz = 1'b0;
    check("w2_b0_fz", bus_2.fz, 1); check("w2_b0", bus_2.z_out, 0);
    @(negedge clk);
    check("w2_b1_fz", bus_2.fz, 1); check("w2_b1", bus_2.z_out, 1);
    @(negedge clk);
    check("w2_done", bus_2.done, 1); check("w2_done_fz", bus_2.fz, 0);
    check("w2_done_ready", bus_2.ready, 0);
    @(negedge clk);
    check("w2_idle_done", bus_2.done, 0); check("w2_idle_ready", bus_2.ready, 1);

    // Cycle-exact frame of A5C3F1 on both 24-bit instances
    for (int i = 0; i < 24; i++) begin
      exp_l[i] = seq030[i];
      exp_m[i] = seq030[23 - i];
    end
    fz_miss = 0;
    @(negedge clk);
    bus_l.z_parallel = 24'hA5C3F1; bus_m.z_parallel = 24'hA5C3F1;
    bus_l.sz = 1'b1; bus_m.sz = 1'b1;
    @(negedge clk); bus_l.sz = 1'b0; bus_m.sz = 1'b0;
    check("load_ready", bus_l.ready, 0);
    for (int k = 0; k < 24; k++) begin
      got_l[k] = bus_l.z_out;
      got_m[k] = bus_m.z_out;
      if (!bus_l.fz || !bus_m.fz) fz_miss++;
      @(negedge clk);
    end
    check("frame_fz_24", fz_miss, 0);
    check("seq_lsb", got_l, exp_l);
    check("seq_msb", got_m, exp_m);
    check("end_done_l", bus_l.done, 1); check("end_done_m", bus_m.done, 1);
    check("end_fz", bus_l.fz, 0); check("end_z_out", bus_l.z_out, 0);
    @(negedge clk);
    check("after_done", bus_l.done, 0); check("after_ready", bus_l.ready, 1);

    // Start edge in the IDLE cycle right after DONE
    bus_l.sz = 1'b1;
    @(negedge clk); bus_l.sz = 1'b0;
    check("b2b_restart", bus_l.fz, 1);
    repeat (28) @(negedge clk);

    // Table of words through both 24-bit instances; z_parallel scrambled after load
    for (int i = 0; i < 5; i++) begin
      int f_l, f_m, d_l, d_m;
      f_l = fr_l; f_m = fr_m; d_l = dn_l; d_m = dn_m;
      @(negedge clk);
      bus_l.z_parallel = vecs[i].word; bus_m.z_parallel = vecs[i].word;
      bus_l.sz = 1'b1; bus_m.sz = 1'b1;
      @(negedge clk);
      bus_l.sz = 1'b0; bus_m.sz = 1'b0;
      bus_l.z_parallel = ~vecs[i].word; bus_m.z_parallel = ~vecs[i].word;
      repeat (28) @(negedge clk);
      @(posedge clk);
      check($sformatf("vec%0d_seq_lsb", i), seq_l, {40'h0, vecs[i].exp_lsb});
      check($sformatf("vec%0d_seq_msb", i), seq_m, {40'h0, vecs[i].exp_msb});
      check($sformatf("vec%0d_len_l", i), len_l, 24);
      check($sformatf("vec%0d_len_m", i), len_m, 24);
      check($sformatf("vec%0d_frames_l", i), fr_l - f_l, 1);
      check($sformatf("vec%0d_frames_m", i), fr_m - f_m, 1);
      check($sformatf("vec%0d_dones_l", i), dn_l - d_l, 1);
      check($sformatf("vec%0d_dones_m", i), dn_m - d_m, 1);
    end

    // Second start edge at SHIFT cycle 10 is ignored
    fl0 = fr_l; dl0 = dn_l;
    @(negedge clk); bus_l.z_parallel = 24'h123456; bus_l.sz = 1'b1;
    @(negedge clk); bus_l.sz = 1'b0;
    repeat (10) @(negedge clk);
    bus_l.sz = 1'b1;
    @(negedge clk); bus_l.sz = 1'b0;
    repeat (40) @(negedge clk);
    @(posedge clk);
    check("mid_pulse_frames", fr_l - fl0, 1);
    check("mid_pulse_dones", dn_l - dl0, 1);
    check("mid_pulse_len", len_l, 24);
    check("mid_pulse_seq", seq_l, 64'h123456);
    check("mid_pulse_idle", bus_l.fz, 0);

    // sz held high 100 cycles: one frame only; then low/high restarts
    fl0 = fr_l; dl0 = dn_l;
    @(negedge clk); bus_l.z_parallel = 24'hA5C3F1; bus_l.sz = 1'b1;
    repeat (100) @(negedge clk);
    bus_l.sz = 1'b0;
    @(negedge clk);
    @(posedge clk);
    check("hold_frames", fr_l - fl0, 1);
    check("hold_dones", dn_l - dl0, 1);
    @(negedge clk); bus_l.sz = 1'b1;
    @(negedge clk); bus_l.sz = 1'b0;
    check("hold_restart", bus_l.fz, 1);
    repeat (28) @(negedge clk);

    // Reset at SHIFT cycle 7, released 3 cycles later with sz high
    fl0 = fr_l; dl0 = dn_l;
    @(negedge clk); bus_l.z_parallel = 24'hA5C3F1; bus_l.sz = 1'b1;
    @(negedge clk); bus_l.sz = 1'b0;
    repeat (7) @(negedge clk);
    #2 reset = 1'b0; bus_l.sz = 1'b1;
    #1;
    check("abort_z_out", bus_l.z_out, 0);
    check("abort_fz", bus_l.fz, 0);
    check("abort_done", bus_l.done, 0);
    check("abort_ready", bus_l.ready, 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    @(posedge clk);
    check("abort_no_restart", bus_l.fz, 0);
    check("abort_no_done", dn_l - dl0, 0);
    check("abort_len", len_l, 8);
    check("abort_frames", fr_l - fl0, 1);
    @(negedge clk); bus_l.sz = 1'b0;
    @(negedge clk); bus_l.sz = 1'b1;
    @(negedge clk); bus_l.sz = 1'b0;
    check("abort_new_frame", bus_l.fz, 1);
    repeat (28) @(negedge clk);
    @(posedge clk);
    check("abort_new_seq", seq_l, 64'hA5C3F1);
    check("abort_new_dones", dn_l - dl0, 1);

    check("ready_z_invariant_l", inv_l, 0);
    check("ready_z_invariant_m", inv_m, 0);
    check("ready_z_invariant_2", inv_2, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
